// File: rtl/icdr_bitslip_deserializer.sv
// Serial-to-parallel capture stage fed by the DPA post divider: shifts serial data on clk,
// loads a W-bit word on each rising edge of div_clk, and rotates the word boundary via bitslip.
module icdr_bitslip_deserializer #(
    parameter int DESER_FACTOR = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sdata,
    input  logic                    div_clk,
    input  logic                    bitslip,
    output logic [DESER_FACTOR-1:0] pout,
    output logic                    pout_valid,
    output logic                    bitslip_busy,
    output logic                    bitslip_rollover
);

    localparam int W  = DESER_FACTOR;
    localparam int HW = 2 * W;
    localparam int SW = (W > 1) ? $clog2(W) : 1;
    localparam int FW = $clog2(HW + 1);

    localparam logic [SW-1:0] SLIP_MAX  = SW'(W - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(HW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_WAIT2 = 2'd2
    } slip_state_t;

    logic [HW-1:0] hist_q;
    logic [HW-1:0] hist_d;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic          div_last_q;
    logic          bs_last_q;
    logic [SW-1:0] slip_q;
    slip_state_t   state_q;
    logic [W-1:0]  pout_q;
    logic          pout_valid_q;
    logic          busy_q;
    logic          rollover_q;

    logic          div_rise;
    logic          bs_rise;
    logic          fill_full;
    logic [W-1:0]  cap_word;
    logic [W-1:0]  cand [W];

    assign div_rise  = div_clk & ~div_last_q;
    assign bs_rise   = bitslip & ~bs_last_q;
    assign fill_full = (fill_q == FILL_FULL);

    assign hist_d = {hist_q[HW-2:0], sdata};
    assign fill_d = fill_full ? fill_q : fill_q + FW'(1);

    // Every legal alignment is a fixed slice; the mux keeps the select within hist.
    for (genvar gi = 0; gi < W; gi++) begin : g_cand
        assign cand[gi] = hist_q[gi +: W];
    end

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < W; i++) begin
            if (slip_q == SW'(i)) begin
                cap_word = cand[i];
            end
        end
    end

    // Datapath: capture uses the pre-edge hist, so the newest bit is the one shifted last edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q       <= '0;
            fill_q       <= '0;
            div_last_q   <= 1'b0;
            bs_last_q    <= 1'b0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            div_last_q   <= div_clk;
            bs_last_q    <= bitslip;
            pout_valid_q <= div_rise & fill_full;
            if (div_rise) begin
                pout_q <= cap_word;
            end
        end
    end

    // Slip handshake: one accepted request, then two captures to let downstream settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            slip_q     <= '0;
            busy_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bs_rise) begin
                        slip_q     <= (slip_q == SLIP_MAX) ? '0 : slip_q + SW'(1);
                        rollover_q <= (slip_q == SLIP_MAX);
                        state_q    <= ST_WAIT1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_WAIT1: begin
                    if (div_rise) begin
                        state_q <= ST_WAIT2;
                    end
                end
                ST_WAIT2: begin
                    if (div_rise) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pout             = pout_q;
    assign pout_valid       = pout_valid_q;
    assign bitslip_busy     = busy_q;
    assign bitslip_rollover = rollover_q;

endmodule

// File: tb/tb_icdr_bitslip_deserializer.sv
// Scoreboard bench for icdr_bitslip_deserializer at W=4 with a repeating 1,0,1,1 stream
// and div_clk of period 4 clks; expected words per slip value are hand-derived constants.
module tb_icdr_bitslip_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         sdata;
    logic         div_clk;
    logic         bitslip;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         bitslip_busy;
    logic         bitslip_rollover;

    icdr_bitslip_deserializer #(.DESER_FACTOR(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .sdata            (sdata),
        .div_clk          (div_clk),
        .bitslip          (bitslip),
        .pout             (pout),
        .pout_valid       (pout_valid),
        .bitslip_busy     (bitslip_busy),
        .bitslip_rollover (bitslip_rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream bit at global edge k is pat_bits[(k+2)%4]; captures fall on k%4==2, so with
    // slip s the word is {sd[n-4-s] .. sd[n-1-s]}, giving these four alignments.
    logic [3:0] pat_bits = 4'b1101;
    logic [3:0] exp_word [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};

    logic [3:0] word_q [$];
    logic [2:0] ctrl_q [$];   // {valid, busy, rollover} expected after each edge

    int   gk = 0;
    int   m_fill;
    int   m_slip;
    int   m_st;
    logic m_dl;
    logic m_bl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n, input logic bs, input logic rst);
        logic dv;
        logic drise;
        logic brise;
        logic roll;
        logic vld;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv      = ((gk % 4) >= 2);
            sdata   = pat_bits[(gk + 2) % 4];
            div_clk = dv;
            bitslip = bs;
            reset   = rst;
            @(posedge clk);
            if (rst) begin
                m_fill = 0; m_slip = 0; m_st = 0; m_dl = 1'b0; m_bl = 1'b0;
                ctrl_q.push_back(3'b000);
            end else begin
                drise = dv & ~m_dl;
                brise = bs & ~m_bl;
                vld   = drise && (m_fill == 2 * W);
                roll  = 1'b0;
                if (vld) word_q.push_back(exp_word[m_slip]);
                if (m_st == 0 && brise) begin
                    roll   = (m_slip == W - 1);
                    m_slip = (m_slip + 1) % W;
                    m_st   = 1;
                end else if (m_st == 1 && drise) begin
                    m_st = 2;
                end else if (m_st == 2 && drise) begin
                    m_st = 0;
                end
                if (m_fill < 2 * W) m_fill++;
                m_dl = dv;
                m_bl = bs;
                ctrl_q.push_back({vld, (m_st != 0), roll});
            end
            gk++;
        end
    endtask

    // Monitor: one expected control triple per edge; a word is popped whenever the DUT flags valid.
    initial begin
        logic [2:0] c;
        logic [3:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (ctrl_q.size() > 0) begin
                c = ctrl_q.pop_front();
                check("pout_valid", 32'(pout_valid), 32'(c[2]));
                check("bitslip_busy", 32'(bitslip_busy), 32'(c[1]));
                check("bitslip_rollover", 32'(bitslip_rollover), 32'(c[0]));
                if (pout_valid) begin
                    if (word_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL pout_unexpected: got %b expected no word at %0t", pout, $time);
                    end else begin
                        w = word_q.pop_front();
                        check("pout_word", 32'(pout), 32'(w));
                        $display("word t=%0t pout=%b exp=%b busy=%b", $time, pout, w, bitslip_busy);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sdata = 1'b0; div_clk = 1'b0; bitslip = 1'b0;

        // Reset during traffic, then plain captures at slip 0.
        run(3, 1'b0, 1'b1);
        #1 check("reset_pout", 32'(pout), 32'd0);
        run(24, 1'b0, 1'b0);

        // Accepted slip, a second request while busy (ignored), then three more accepted
        // slips: the fourth wraps 3->0 and pulses rollover.
        run(1, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(12, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(12, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(14, 1'b0, 1'b0);

        // Slip request on the same edge as a capture.
        while ((gk % 4) != 2) run(1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(16, 1'b0, 1'b0);

        // Reset while a slip is in progress, with a request coinciding with reset.
        run(1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        #1 check("midreset_pout", 32'(pout), 32'd0);
        run(24, 1'b0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        #2;
        check("words_left", 32'(word_q.size()), 32'd0);
        check("ctrl_left", 32'(ctrl_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
